// File: rtl/ctrl_pipe.sv
// Instruction decode stage with a one-deep output register, immediate prefix
// handling and squashing of instructions that follow a taken branch.
module ctrl_pipe #(
   parameter int OPWIDTH       = 4,
   parameter int SQUASH_CYCLES = 2
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [8:0]         instr,
   input  logic               branch_taken,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               RegWrite,
   output logic               MemWrite,
   output logic               MemToReg,
   output logic               TruncatedReg,
   output logic               TruncPrefix,
   output logic               AbsBranch,
   output logic               RelBranch,
   output logic               BranchInvert,
   output logic               BranchFlag,
   output logic               ParityOp,
   output logic               illegal,
   output logic               squashed,
   output logic [1:0]         SecondOperand,
   output logic [OPWIDTH-1:0] ALUOp,
   output logic [7:0]         Imm8
);

   localparam int SCW = $clog2(SQUASH_CYCLES + 1);
   localparam logic [SCW-1:0] SC_LOAD = SCW'(SQUASH_CYCLES);

   localparam logic [0:0] NORMAL   = 1'b0;
   localparam logic [0:0] PFX_PEND = 1'b1;

   logic [0:0]         r_state;
   logic [2:0]         r_pfx;
   logic [SCW-1:0]     r_sc;

   logic               r_outValid;
   logic               r_regWrite, r_memWrite, r_memToReg, r_truncReg, r_truncPrefix;
   logic               r_absBranch, r_relBranch, r_branchInvert, r_branchFlag;
   logic               r_parityOp, r_illegal, r_squashed;
   logic [1:0]         r_secondOp;
   logic [OPWIDTH-1:0] r_aluOp;
   logic [7:0]         r_imm;

   logic [2:0]         w_opcode;
   logic [3:0]         w_mode;
   logic               w_accept, w_squash, w_isPfx, w_emit;
   logic               w_regWrite, w_memWrite, w_memToReg, w_truncReg, w_truncPrefix;
   logic               w_absBranch, w_relBranch, w_branchInvert, w_branchFlag;
   logic               w_parityOp, w_illegal;
   logic [1:0]         w_secondOp;
   logic [OPWIDTH-1:0] w_aluOp;
   logic [OPWIDTH-1:0] w_parityAlu;
   logic [7:0]         w_imm;

   assign w_opcode = instr[8:6];
   assign w_mode   = instr[3:0];
   assign in_ready = ~r_outValid | out_ready;
   assign w_accept = in_valid & in_ready;
   assign w_squash = branch_taken | (r_sc != '0);
   assign w_isPfx  = (w_opcode == 3'b101) && (w_mode[2:0] == 3'b001);
   // A prefix never occupies the output stage, squashed or not.
   assign w_emit   = w_accept & ~w_isPfx;

   always_comb begin
      w_parityAlu = '0;
      for (int i = 0; i < 4; i++) begin
         if (i <= OPWIDTH - 2) w_parityAlu[i] = w_mode[i];
      end
      w_parityAlu[OPWIDTH-1] = 1'b1;
   end

   always_comb begin
      w_regWrite     = 1'b1;
      w_memWrite     = 1'b0;
      w_memToReg     = 1'b0;
      w_truncReg     = 1'b0;
      w_truncPrefix  = 1'b0;
      w_absBranch    = 1'b0;
      w_relBranch    = 1'b0;
      w_branchInvert = 1'b0;
      w_branchFlag   = 1'b0;
      w_parityOp     = 1'b0;
      w_illegal      = 1'b0;
      w_secondOp     = 2'b01;
      w_aluOp        = '0;
      w_imm          = {{4{w_mode[3]}}, w_mode};
      case (w_opcode)
         3'b000: w_aluOp = '0;
         3'b001: w_aluOp = OPWIDTH'(1);
         3'b010: w_aluOp = OPWIDTH'(2);
         3'b011: begin
            w_aluOp    = OPWIDTH'(1);
            w_truncReg = 1'b1;
            w_secondOp = 2'b00;
            if (w_mode[3]) begin
               w_memWrite = 1'b1;
               w_regWrite = 1'b0;
            end else begin
               w_memToReg = 1'b1;
            end
         end
         3'b100: begin
            w_truncReg    = 1'b1;
            w_truncPrefix = 1'b1;
            w_secondOp    = 2'b10;
            if (r_state == PFX_PEND) w_imm = {r_pfx[2], r_pfx, w_mode};
         end
         3'b101: begin
            case (w_mode[2:0])
               3'b000:  w_aluOp = OPWIDTH'(4);
               3'b010:  w_aluOp = OPWIDTH'(5);
               3'b011:  w_aluOp = OPWIDTH'(3);
               3'b100:  w_aluOp = OPWIDTH'(6);
               3'b110:  w_aluOp = OPWIDTH'(7);
               3'b001:  w_aluOp = '0;
               default: begin
                  w_illegal  = 1'b1;
                  w_regWrite = 1'b0;
               end
            endcase
         end
         3'b110: begin
            w_regWrite     = 1'b0;
            w_absBranch    = w_mode[0];
            w_relBranch    = ~w_mode[0];
            w_branchFlag   = w_mode[1];
            w_branchInvert = w_mode[2];
         end
         default: begin
            w_parityOp = 1'b1;
            w_aluOp    = w_parityAlu;
         end
      endcase
      // Squashed words keep their decode but lose every architectural side effect.
      if (w_squash) begin
         w_regWrite  = 1'b0;
         w_memWrite  = 1'b0;
         w_absBranch = 1'b0;
         w_relBranch = 1'b0;
         w_illegal   = 1'b0;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_outValid     <= 1'b0;
         r_regWrite     <= 1'b0;
         r_memWrite     <= 1'b0;
         r_memToReg     <= 1'b0;
         r_truncReg     <= 1'b0;
         r_truncPrefix  <= 1'b0;
         r_absBranch    <= 1'b0;
         r_relBranch    <= 1'b0;
         r_branchInvert <= 1'b0;
         r_branchFlag   <= 1'b0;
         r_parityOp     <= 1'b0;
         r_illegal      <= 1'b0;
         r_squashed     <= 1'b0;
         r_secondOp     <= 2'b00;
         r_aluOp        <= '0;
         r_imm          <= 8'h00;
      end else if (w_emit) begin
         r_outValid     <= 1'b1;
         r_regWrite     <= w_regWrite;
         r_memWrite     <= w_memWrite;
         r_memToReg     <= w_memToReg;
         r_truncReg     <= w_truncReg;
         r_truncPrefix  <= w_truncPrefix;
         r_absBranch    <= w_absBranch;
         r_relBranch    <= w_relBranch;
         r_branchInvert <= w_branchInvert;
         r_branchFlag   <= w_branchFlag;
         r_parityOp     <= w_parityOp;
         r_illegal      <= w_illegal;
         r_squashed     <= w_squash;
         r_secondOp     <= w_secondOp;
         r_aluOp        <= w_aluOp;
         r_imm          <= w_imm;
      end else if (out_ready) begin
         r_outValid <= 1'b0;
      end
   end

   // The instruction accepted alongside branch_taken uses up one squash slot.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_sc <= '0;
      end else if (branch_taken) begin
         r_sc <= SC_LOAD - SCW'(w_accept);
      end else if (w_accept && (r_sc != '0)) begin
         r_sc <= r_sc - SCW'(1);
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state <= NORMAL;
         r_pfx   <= 3'b000;
      end else if (branch_taken) begin
         r_state <= NORMAL;
      end else if (w_accept && !w_squash) begin
         if (w_isPfx) begin
            r_state <= PFX_PEND;
            r_pfx   <= instr[5:3];
         end else begin
            r_state <= NORMAL;
         end
      end
   end

   assign out_valid     = r_outValid;
   assign RegWrite      = r_regWrite;
   assign MemWrite      = r_memWrite;
   assign MemToReg      = r_memToReg;
   assign TruncatedReg  = r_truncReg;
   assign TruncPrefix   = r_truncPrefix;
   assign AbsBranch     = r_absBranch;
   assign RelBranch     = r_relBranch;
   assign BranchInvert  = r_branchInvert;
   assign BranchFlag    = r_branchFlag;
   assign ParityOp      = r_parityOp;
   assign illegal       = r_illegal;
   assign squashed      = r_squashed;
   assign SecondOperand = r_secondOp;
   assign ALUOp         = r_aluOp;
   assign Imm8          = r_imm;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: directed scenarios followed by random
// traffic, all compared against an instruction-level reference model.
module tb_ctrl_pipe;

   localparam int OPW = 4;
   localparam int SQ  = 2;

   localparam logic [8:0] ADD      = 9'b000_00_0000;
   localparam logic [8:0] XOR      = 9'b001_00_0000;
   localparam logic [8:0] AND      = 9'b010_00_0000;
   localparam logic [8:0] STO      = 9'b011_00_1000;
   localparam logic [8:0] ADDI_F   = 9'b100_00_1111;
   localparam logic [8:0] ADDI_5   = 9'b100_00_0101;
   localparam logic [8:0] ADDI_1   = 9'b100_00_0001;
   localparam logic [8:0] PFX_3    = 9'b101_011_001;
   localparam logic [8:0] SHIFT_BAD = 9'b101_00_0101;
   localparam logic [8:0] PARITY_6 = 9'b111_00_0110;

   logic           Clk = 1'b0;
   logic           Reset = 1'b1;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [8:0]     instr = '0;
   logic           branch_taken = 1'b0;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic           RegWrite, MemWrite, MemToReg, TruncatedReg, TruncPrefix;
   logic           AbsBranch, RelBranch, BranchInvert, BranchFlag;
   logic           ParityOp, illegal, squashed;
   logic [1:0]     SecondOperand;
   logic [OPW-1:0] ALUOp;
   logic [7:0]     Imm8;
   logic [25:0]    dutWord;

   int checks = 0;
   int failures = 0;

   bit          mValid = 1'b0;
   logic [25:0] mWord = '0;
   bit          mPend = 1'b0;
   int          mPfx = 0;
   int          mKill = 0;

   ctrl_pipe #(.OPWIDTH(OPW), .SQUASH_CYCLES(SQ)) dut (
      .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .branch_taken(branch_taken), .out_valid(out_valid),
      .out_ready(out_ready), .RegWrite(RegWrite), .MemWrite(MemWrite),
      .MemToReg(MemToReg), .TruncatedReg(TruncatedReg), .TruncPrefix(TruncPrefix),
      .AbsBranch(AbsBranch), .RelBranch(RelBranch), .BranchInvert(BranchInvert),
      .BranchFlag(BranchFlag), .ParityOp(ParityOp), .illegal(illegal),
      .squashed(squashed), .SecondOperand(SecondOperand), .ALUOp(ALUOp), .Imm8(Imm8)
   );

   always #5 Clk = ~Clk;

   assign dutWord = {RegWrite, MemWrite, MemToReg, TruncatedReg, TruncPrefix,
                     AbsBranch, RelBranch, BranchInvert, BranchFlag, ParityOp,
                     illegal, squashed, SecondOperand, ALUOp, Imm8};

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Instruction-level meaning of one emitted word, straight from the decode table.
   function automatic logic [25:0] refDecode(input logic [8:0] ins, input bit pend,
                                            input int pfx, input bit kill);
      int op, mode, rw, mw, m2r, tr, tp, ab, rb, bi, bf, po, ill, so, alu, imm, kl;
      op = int'(ins[8:6]);
      mode = int'(ins[3:0]);
      rw = 1; mw = 0; m2r = 0; tr = 0; tp = 0; ab = 0; rb = 0; bi = 0; bf = 0;
      po = 0; ill = 0; so = 1; alu = 0;
      imm = (mode >= 8) ? mode + 240 : mode;
      kl = kill ? 1 : 0;
      case (op)
         1: alu = 1;
         2: alu = 2;
         3: begin
            alu = 1; tr = 1; so = 0;
            if (mode >= 8) begin mw = 1; rw = 0; end
            else m2r = 1;
         end
         4: begin
            tr = 1; tp = 1; so = 2;
            if (pend) imm = (pfx / 4) * 128 + pfx * 16 + mode;
         end
         5: begin
            case (mode % 8)
               0: alu = 4;
               2: alu = 5;
               3: alu = 3;
               4: alu = 6;
               6: alu = 7;
               default: begin ill = 1; rw = 0; end
            endcase
         end
         6: begin
            rw = 0; ab = mode % 2; rb = 1 - mode % 2;
            bf = (mode / 2) % 2; bi = (mode / 4) % 2;
         end
         7: begin po = 1; alu = 8 + mode % 8; end
         default: alu = 0;
      endcase
      if (kill) begin rw = 0; mw = 0; ab = 0; rb = 0; ill = 0; end
      return {rw[0], mw[0], m2r[0], tr[0], tp[0], ab[0], rb[0], bi[0], bf[0],
              po[0], ill[0], kl[0], so[1:0], alu[3:0], imm[7:0]};
   endfunction

   // One clock of traffic: drive, predict, step the model, then compare outputs.
   task automatic applyStimulus(input logic v, input logic [8:0] ins,
                                input logic bt, input logic ordy);
      bit ready, acc, kill, isPfx;
      int op, mode;
      in_valid = v; instr = ins; branch_taken = bt; out_ready = ordy;
      #1;
      ready = !mValid || ordy;
      checkOutput("in_ready", 32'(in_ready), 32'(ready));
      op = int'(ins[8:6]);
      mode = int'(ins[3:0]);
      acc = v && ready;
      kill = bt || (mKill > 0);
      isPfx = (op == 5) && (mode % 8 == 1);
      if (acc && !isPfx) begin
         mWord = refDecode(ins, mPend, mPfx, kill);
         mValid = 1'b1;
      end else if (ordy) begin
         mValid = 1'b0;
      end
      if (bt) mKill = SQ - (acc ? 1 : 0);
      else if (acc && mKill > 0) mKill--;
      if (bt) mPend = 1'b0;
      else if (acc && !kill) begin
         if (isPfx) begin mPend = 1'b1; mPfx = int'(ins[5:3]); end
         else mPend = 1'b0;
      end
      @(posedge Clk);
      #1;
      checkOutput("out_valid", 32'(out_valid), 32'(mValid));
      if (mValid) checkOutput("word", 32'(dutWord), 32'(mWord));
   endtask

   // Asynchronous reset asserted between edges; released just after an edge.
   task automatic doReset();
      Reset = 1'b1;
      in_valid = 1'b1; instr = ADD; out_ready = 1'b0;
      #2;
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_word", 32'(dutWord), 32'd0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge Clk);
      #1;
      checkOutput("rst_hold_valid", 32'(out_valid), 32'd0);
      Reset = 1'b0;
      in_valid = 1'b0;
      mValid = 1'b0; mWord = '0; mPend = 1'b0; mPfx = 0; mKill = 0;
   endtask

   initial begin
      logic [8:0] rIns;
      doReset();

      applyStimulus(1'b1, ADDI_F, 1'b0, 1'b1);
      checkOutput("addi_imm", 32'(Imm8), 32'hFF);
      checkOutput("addi_secop", 32'(SecondOperand), 32'd2);
      checkOutput("addi_truncpfx", 32'(TruncPrefix), 32'd1);
      checkOutput("addi_regwrite", 32'(RegWrite), 32'd1);

      applyStimulus(1'b1, PFX_3, 1'b0, 1'b1);
      checkOutput("pfx_no_word", 32'(out_valid), 32'd0);
      applyStimulus(1'b1, ADDI_5, 1'b0, 1'b1);
      checkOutput("pfx_addi_imm", 32'(Imm8), 32'h35);
      applyStimulus(1'b1, ADDI_5, 1'b0, 1'b1);
      checkOutput("pfx_cleared_imm", 32'(Imm8), 32'h05);

      applyStimulus(1'b1, STO, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, ADD, 1'b0, 1'b0);
         checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
         checkOutput("stall_memwrite", 32'(MemWrite), 32'd1);
         checkOutput("stall_regwrite", 32'(RegWrite), 32'd0);
      end
      applyStimulus(1'b1, ADD, 1'b0, 1'b1);
      checkOutput("release_memwrite", 32'(MemWrite), 32'd0);
      checkOutput("release_regwrite", 32'(RegWrite), 32'd1);

      applyStimulus(1'b1, ADD, 1'b1, 1'b1);
      checkOutput("sq_add_squashed", 32'(squashed), 32'd1);
      checkOutput("sq_add_regwrite", 32'(RegWrite), 32'd0);
      applyStimulus(1'b1, XOR, 1'b0, 1'b1);
      checkOutput("sq_xor_squashed", 32'(squashed), 32'd1);
      applyStimulus(1'b1, AND, 1'b0, 1'b1);
      checkOutput("sq_and_squashed", 32'(squashed), 32'd0);
      checkOutput("sq_and_regwrite", 32'(RegWrite), 32'd1);

      applyStimulus(1'b1, SHIFT_BAD, 1'b0, 1'b1);
      checkOutput("shift_illegal", 32'(illegal), 32'd1);
      checkOutput("shift_regwrite", 32'(RegWrite), 32'd0);
      applyStimulus(1'b1, PARITY_6, 1'b0, 1'b1);
      checkOutput("parity_op", 32'(ParityOp), 32'd1);
      checkOutput("parity_alu", 32'(ALUOp), 32'hE);

      applyStimulus(1'b1, ADD, 1'b0, 1'b0);
      doReset();
      applyStimulus(1'b1, PFX_3, 1'b0, 1'b1);
      doReset();
      applyStimulus(1'b1, ADDI_1, 1'b0, 1'b1);
      checkOutput("post_rst_imm", 32'(Imm8), 32'h01);

      for (int n = 0; n < 600; n++) begin
         rIns = 9'($urandom);
         if ($urandom_range(0, 5) == 0) rIns = {3'b101, rIns[5:3], 3'b001};
         applyStimulus(1'($urandom_range(0, 3) != 0), rIns,
                       1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) != 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
